// File: rtl/pipeline_ctrl_if.sv
// Handshake bundle between the pipeline datapath and its hazard/sequencing controller.
// The controller takes the master view; the pipeline registers take the slave view.
interface pipeline_ctrl_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_use_rs;
  logic             id_use_rt;
  logic             id_div;
  logic             id_use_hilo;
  logic             ex_wreg;
  logic             ex_m2reg;
  logic [REG_W-1:0] ex_rn;
  logic             branch_taken;
  logic             mem_busy;

  logic             pc_en;
  logic             ifid_en;
  logic             condep;
  logic             idex_en;
  logic             idex_clr;
  logic             div_start;
  logic             div_busy;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    input  id_rs, id_rt, id_use_rs, id_use_rt, id_div, id_use_hilo,
    input  ex_wreg, ex_m2reg, ex_rn, branch_taken, mem_busy,
    output pc_en, ifid_en, condep, idex_en, idex_clr,
    output div_start, div_busy, stall_cnt, flush_cnt
  );

  modport slave (
    output id_rs, id_rt, id_use_rs, id_use_rt, id_div, id_use_hilo,
    output ex_wreg, ex_m2reg, ex_rn, branch_taken, mem_busy,
    input  pc_en, ifid_en, condep, idex_en, idex_clr,
    input  div_start, div_busy, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: freeze > flush > hazard stall > run,
// plus issue scheduling for the single shared multi-cycle divider.
module pipeline_ctrl #(
  parameter int REG_W   = 5,
  parameter int DIV_CYC = 32,
  parameter int CNT_W   = 16
) (
  input  logic             Clk,
  input  logic             Clrn,
  pipeline_ctrl_if.master  bus
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } div_state_t;

  localparam logic [7:0] DCNT_LOAD = 8'(DIV_CYC - 1);

  div_state_t       state_q, state_d;
  logic [7:0]       dcnt_q, dcnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic lu;
  logic dh;
  logic div_busy;
  logic pc_en, ifid_en, condep, idex_en, idex_clr, div_start;
  logic stall_inc, flush_inc;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + CNT_W'(1);
  endfunction

  // r0 is hardwired, so a load targeting it can never feed a dependent read
  assign lu = bus.ex_wreg & bus.ex_m2reg & (bus.ex_rn != '0) &
              ((bus.id_use_rs & (bus.id_rs == bus.ex_rn)) |
               (bus.id_use_rt & (bus.id_rt == bus.ex_rn)));

  assign div_busy = (state_q == BUSY) & ~Clrn;
  assign dh       = div_busy & (bus.id_div | bus.id_use_hilo);

  always_comb begin
    pc_en     = 1'b1;
    ifid_en   = 1'b1;
    idex_en   = 1'b1;
    condep    = 1'b0;
    idex_clr  = 1'b0;
    div_start = 1'b0;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    if (Clrn) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      condep   = 1'b1;
      idex_clr = 1'b1;
    end else if (bus.mem_busy) begin
      // branch stays in EX during a freeze and reasserts once memory frees up
      pc_en   = 1'b0;
      ifid_en = 1'b0;
      idex_en = 1'b0;
    end else if (bus.branch_taken) begin
      condep    = 1'b1;
      idex_clr  = 1'b1;
      flush_inc = 1'b1;
    end else if (lu | dh) begin
      pc_en     = 1'b0;
      ifid_en   = 1'b0;
      idex_clr  = 1'b1;
      stall_inc = 1'b1;
    end else begin
      div_start = bus.id_div & ~div_busy;
    end
  end

  // Divider occupancy keeps running through freezes and flushes
  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    unique case (state_q)
      IDLE: begin
        if (div_start) begin
          state_d = BUSY;
          dcnt_d  = DCNT_LOAD;
        end
      end
      BUSY: begin
        if (dcnt_q != 8'd0) dcnt_d = dcnt_q - 8'd1;
        else                state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_inc) stall_cnt_d = sat_inc(stall_cnt_q);
    if (flush_inc) flush_cnt_d = sat_inc(flush_cnt_q);
  end

  always_ff @(posedge Clk or posedge Clrn) begin
    if (Clrn) begin
      state_q     <= IDLE;
      dcnt_q      <= 8'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      dcnt_q      <= dcnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.pc_en     = pc_en;
  assign bus.ifid_en   = ifid_en;
  assign bus.condep    = condep;
  assign bus.idex_en   = idex_en;
  assign bus.idex_clr  = idex_clr;
  assign bus.div_start = div_start;
  assign bus.div_busy  = div_busy;
  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;

endmodule
